hilo_wb_pipe: RTL and testbench

//  Consumer side of the EX-stage HI/LO write interface (whilo/hi/lo). Carries EX HI/LO

---
 rtl/hilo_wb_pipe.sv | 165 ++++++++++++++++
 tb/tb_hilo_wb_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_wb_pipe.sv
// hilo_wb_pipe
//   Consumer side of the EX-stage HI/LO write interface. A HI/LO write from EX
//   travels through the EX/MEM and MEM/WB registers and is committed to the
//   architectural HI/LO pair when it leaves MEM/WB. The raw stage registers are
//   exported as forwarding taps, and the committed pair is exported as the read
//   value.
//
//   Build option: define HILO_BYPASS_EN to let a pending MEM/WB write show
//   through on hi_o/lo_o one cycle before it is committed. When the macro is
//   undefined, hi_o/lo_o are driven purely from registers.
module hilo_wb_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic              ex_whilo_i,
    input  logic [DATA_W-1:0] ex_hi_i,
    input  logic [DATA_W-1:0] ex_lo_i,
    output logic              mem_whilo_o,
    output logic [DATA_W-1:0] mem_hi_o,
    output logic [DATA_W-1:0] mem_lo_o,
    output logic              wb_whilo_o,
    output logic [DATA_W-1:0] wb_hi_o,
    output logic [DATA_W-1:0] wb_lo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [7:0]        commit_cnt_o
);

    // EX/MEM stage registers
    logic              mem_whilo_q, mem_whilo_d;
    logic [DATA_W-1:0] mem_hi_q,    mem_hi_d;
    logic [DATA_W-1:0] mem_lo_q,    mem_lo_d;

    // MEM/WB stage registers
    logic              wb_whilo_q,  wb_whilo_d;
    logic [DATA_W-1:0] wb_hi_q,     wb_hi_d;
    logic [DATA_W-1:0] wb_lo_q,     wb_lo_d;

    // Architectural HI/LO and commit counter
    logic [DATA_W-1:0] hi_q,        hi_d;
    logic [DATA_W-1:0] lo_q,        lo_d;
    logic [7:0]        cnt_q,       cnt_d;

    // Stage control. A WB-only stall cannot legally occur (stalls propagate
    // downstream-first); if it does, it is folded into a full stall so no
    // entry is ever overwritten while MEM/WB is holding.
    logic hold_mem;
    logic hold_wb;
    logic bubble_wb;
    logic commit;

    assign hold_wb   = stall_wb;
    assign hold_mem  = stall_mem | stall_wb;
    assign bubble_wb = hold_mem & ~hold_wb;

    // The commit reads the pre-edge MEM/WB contents, so a flush on the same
    // edge does not cancel it. A held WB entry commits only when released.
    assign commit    = wb_whilo_q & ~hold_wb;

    // EX/MEM next state: flush kills, a stall holds, otherwise capture EX.
    always_comb begin
        mem_whilo_d = mem_whilo_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        if (flush) begin
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
        end else if (!hold_mem) begin
            mem_whilo_d = ex_whilo_i;
            mem_hi_d    = ex_hi_i;
            mem_lo_d    = ex_lo_i;
        end
    end

    // MEM/WB next state: flush or an upstream-only stall loads a bubble,
    // a WB stall holds, otherwise advance the EX/MEM contents.
    always_comb begin
        wb_whilo_d = wb_whilo_q;
        wb_hi_d    = wb_hi_q;
        wb_lo_d    = wb_lo_q;
        if (flush || bubble_wb) begin
            wb_whilo_d = 1'b0;
            wb_hi_d    = '0;
            wb_lo_d    = '0;
        end else if (!hold_wb) begin
            wb_whilo_d = mem_whilo_q;
            wb_hi_d    = mem_hi_q;
            wb_lo_d    = mem_lo_q;
        end
    end

    // Architectural next state: both words are always written together.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        if (commit) begin
            hi_d  = wb_hi_q;
            lo_d  = wb_lo_q;
            cnt_d = cnt_q + 8'd1;
        end
    end

    // EX -> MEM pipeline boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_whilo_q <= 1'b0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
        end else begin
            mem_whilo_q <= mem_whilo_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
        end
    end

    // MEM -> WB pipeline boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_whilo_q <= 1'b0;
            wb_hi_q    <= '0;
            wb_lo_q    <= '0;
        end else begin
            wb_whilo_q <= wb_whilo_d;
            wb_hi_q    <= wb_hi_d;
            wb_lo_q    <= wb_lo_d;
        end
    end

    // WB -> architectural HI/LO commit boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= 8'd0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    assign mem_whilo_o  = mem_whilo_q;
    assign mem_hi_o     = mem_hi_q;
    assign mem_lo_o     = mem_lo_q;
    assign wb_whilo_o   = wb_whilo_q;
    assign wb_hi_o      = wb_hi_q;
    assign wb_lo_o      = wb_lo_q;
    assign commit_cnt_o = cnt_q;

`ifdef HILO_BYPASS_EN
    // Write-through: a pending WB write is visible before it commits.
    assign hi_o = wb_whilo_q ? wb_hi_q : hi_q;
    assign lo_o = wb_whilo_q ? wb_lo_q : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_wb_pipe.sv
// tb_hilo_wb_pipe
//   Scoreboard bench for hilo_wb_pipe. The driver keeps a transaction-level
//   picture of where each HI/LO write sits (EX/MEM slot, MEM/WB slot, committed
//   pair) and, every cycle, queues the outputs it expects plus any commit it
//   expects. A separate monitor on the falling edge pops and compares.
module tb_hilo_wb_pipe;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         stall_mem;
    logic         stall_wb;
    logic         flush;
    logic         ex_whilo_i;
    logic [W-1:0] ex_hi_i;
    logic [W-1:0] ex_lo_i;
    logic         mem_whilo_o;
    logic [W-1:0] mem_hi_o;
    logic [W-1:0] mem_lo_o;
    logic         wb_whilo_o;
    logic [W-1:0] wb_hi_o;
    logic [W-1:0] wb_lo_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic [7:0]   commit_cnt_o;

    hilo_wb_pipe #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_mem    (stall_mem),
        .stall_wb     (stall_wb),
        .flush        (flush),
        .ex_whilo_i   (ex_whilo_i),
        .ex_hi_i      (ex_hi_i),
        .ex_lo_i      (ex_lo_i),
        .mem_whilo_o  (mem_whilo_o),
        .mem_hi_o     (mem_hi_o),
        .mem_lo_o     (mem_lo_o),
        .wb_whilo_o   (wb_whilo_o),
        .wb_hi_o      (wb_hi_o),
        .wb_lo_o      (wb_lo_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .commit_cnt_o (commit_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } slot_t;

    typedef struct packed {
        slot_t        mem;
        slot_t        wb;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [7:0]   cnt;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } cmt_t;

    exp_t out_q[$];
    cmt_t cmt_q[$];

    // Reference picture of the pipe: occupancy of the two slots and the
    // committed architectural state.
    slot_t        m_mem;
    slot_t        m_wb;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [7:0]   m_cnt;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle of stimulus, queue what must be observed during it,
    // then move the reference picture across the coming clock edge.
    task automatic step(input bit r, input bit f, input bit sm, input bit sw,
                        input bit we, input logic [W-1:0] h, input logic [W-1:0] l);
        slot_t ex_slot;
        rst        = r;
        flush      = f;
        stall_mem  = sm;
        stall_wb   = sw;
        ex_whilo_i = we;
        ex_hi_i    = h;
        ex_lo_i    = l;
        out_q.push_back('{m_mem, m_wb, m_hi, m_lo, m_cnt});
        if (!r && m_wb.v && !sw) cmt_q.push_back('{m_wb.hi, m_wb.lo});

        if (r) begin
            m_mem = empty_slot();
            m_wb  = empty_slot();
            m_hi  = '0;
            m_lo  = '0;
            m_cnt = 8'd0;
        end else begin
            // The write leaving WB retires into HI/LO unless WB is held.
            if (m_wb.v && !sw) begin
                m_hi  = m_wb.hi;
                m_lo  = m_wb.lo;
                m_cnt = m_cnt + 8'd1;
            end
            ex_slot = '{we, h, l};
            if (f) begin
                m_mem = empty_slot();
                m_wb  = empty_slot();
            end else if (sm) begin
                // MEM keeps its write; WB keeps its own if held, else gets nothing.
                if (!sw) m_wb = empty_slot();
            end else begin
                m_wb  = m_mem;
                m_mem = ex_slot;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic wr(input logic [W-1:0] h, input logic [W-1:0] l);
        step(0, 0, 0, 0, 1, h, l);
    endtask

    // Monitor: compare every queued cycle expectation and every commit strobe.
    exp_t         e_m;
    cmt_t         c_m;
    logic [W-1:0] exp_hi_o;
    logic [W-1:0] exp_lo_o;
    always @(negedge clk) begin
        if (out_q.size() > 0) begin
            e_m = out_q.pop_front();
            check("mem_whilo", {31'd0, mem_whilo_o}, {31'd0, e_m.mem.v});
            check("mem_hi", mem_hi_o, e_m.mem.hi);
            check("mem_lo", mem_lo_o, e_m.mem.lo);
            check("wb_whilo", {31'd0, wb_whilo_o}, {31'd0, e_m.wb.v});
            check("wb_hi", wb_hi_o, e_m.wb.hi);
            check("wb_lo", wb_lo_o, e_m.wb.lo);
`ifdef HILO_BYPASS_EN
            exp_hi_o = e_m.wb.v ? e_m.wb.hi : e_m.hi;
            exp_lo_o = e_m.wb.v ? e_m.wb.lo : e_m.lo;
`else
            exp_hi_o = e_m.hi;
            exp_lo_o = e_m.lo;
`endif
            check("hi_o", hi_o, exp_hi_o);
            check("lo_o", lo_o, exp_lo_o);
            check("commit_cnt", {24'd0, commit_cnt_o}, {24'd0, e_m.cnt});

            if (wb_whilo_o && !stall_wb && !rst) begin
                if (cmt_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_commit: got hi %h lo %h expected no commit", wb_hi_o, wb_lo_o);
                end else begin
                    c_m = cmt_q.pop_front();
                    check("commit_hi", wb_hi_o, c_m.hi);
                    check("commit_lo", wb_lo_o, c_m.lo);
                end
            end else if (cmt_q.size() > 0) begin
                c_m = cmt_q.pop_front();
                n_total++;
                $display("FAIL missing_commit: got no strobe expected commit hi %h lo %h", c_m.hi, c_m.lo);
            end
        end
    end

    logic [W-1:0] a_hi, a_lo, b_hi, b_lo;
    logic [7:0]   cnt_before;
    logic [W-1:0] last_hi;

    initial begin
        rst = 1'b1; flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
        ex_whilo_i = 1'b0; ex_hi_i = '0; ex_lo_i = '0;
        m_mem = '0; m_wb = '0; m_hi = '0; m_lo = '0; m_cnt = 8'd0;
        @(posedge clk);
        #1;

        // Reset with a write held at EX: nothing may enter the pipe.
        step(1, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        idle(3);
        check("rst_hi_stays_0", hi_o, 32'd0);

        // Single write, then drain.
        wr(32'h1234_5678, 32'h9ABC_DEF0);
        idle(4);
        check("single_hi", hi_o, 32'h1234_5678);
        check("single_cnt", {24'd0, commit_cnt_o}, 32'd1);

        // Back-to-back writes.
        wr(32'hAAAA_0001, 32'h5555_0001);
        wr(32'hBBBB_0002, 32'h6666_0002);
        idle(4);
        check("b2b_cnt", {24'd0, commit_cnt_o}, 32'd3);

        // Upstream stall: three bubbles into WB, single commit after release.
        wr(32'h0A0A_0A0A, 32'h0B0B_0B0B);
        repeat (3) step(0, 0, 1, 0, 0, '0, '0);
        idle(4);

        // Full stall with the write sitting in WB: it must commit once.
        wr(32'h0C0C_0C0C, 32'h0D0D_0D0D);
        idle(1);
        repeat (2) step(0, 0, 1, 1, 0, '0, '0);
        idle(3);

        // Flush one cycle after a write: the write never reaches WB.
        wr(32'hF1F1_F1F1, 32'hF2F2_F2F2);
        step(0, 1, 0, 0, 0, '0, '0);
        idle(3);

        // Flush coinciding with a commit: A commits, B is killed.
        a_hi = $urandom; a_lo = $urandom; b_hi = $urandom; b_lo = $urandom;
        wr(a_hi, a_lo);
        wr(b_hi, b_lo);
        step(0, 1, 0, 0, 0, '0, '0);
        idle(3);
        check("flush_commit_hi", hi_o, a_hi);

        // 256 consecutive writes: counter wraps back to its starting value.
        cnt_before = commit_cnt_o;
        last_hi = '0;
        for (int i = 0; i < 256; i++) begin
            last_hi = $urandom;
            wr(last_hi, $urandom);
        end
        idle(4);
        check("wrap_cnt", {24'd0, commit_cnt_o}, {24'd0, cnt_before});
        check("wrap_last_hi", hi_o, last_hi);

        // Randomized traffic with legal stall combinations, flushes and resets.
        for (int i = 0; i < 600; i++) begin
            bit r, f, sm, sw, we;
            r  = ($urandom_range(0, 59) == 0);
            f  = ($urandom_range(0, 9) == 0);
            sw = ($urandom_range(0, 5) == 0);
            sm = sw ? 1'b1 : ($urandom_range(0, 3) == 0);
            we = ($urandom_range(0, 2) != 0);
            step(r, f, sm, sw, we, $urandom, $urandom);
        end
        idle(4);

        @(negedge clk);
        #1;
        check("cmt_q_drained", cmt_q.size(), 32'd0);
        check("out_q_drained", out_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
